// File: rtl/gf_sqrt_seq_if.sv
// -----------------------------------------------------------------------------
// gf_sqrt_seq_if
// Handshake bundle for the GF(2^M) sequential square-root unit.
//
// Optional feature macro: GF_SQRT_CHECK_EN (adds chk_err).
//
// Valid/ready semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds valid and its
// data stable until that edge; ready may be asserted without valid.
//
// Signals
//   in_valid   upstream -> unit   operand in_a is valid
//   in_ready   unit -> upstream   unit can accept an operand this cycle
//   in_a       upstream -> unit   operand a, polynomial basis (bit i = x^i)
//   out_valid  unit -> downstream out_sqrt is valid
//   out_ready  downstream -> unit result accepted this cycle
//   out_sqrt   unit -> downstream sqrt(a)
//   busy       unit -> observer   high while squaring (RUN)
//   dbg_state  unit -> observer   raw FSM state (0 IDLE, 1 RUN, 2 DONE)
//   chk_err    unit -> observer   self-check flag (GF_SQRT_CHECK_EN only)
// -----------------------------------------------------------------------------
interface gf_sqrt_seq_if #(
   parameter int M = 3
) ();
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] in_a;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] out_sqrt;
   logic         busy;
   logic [1:0]   dbg_state;
`ifdef GF_SQRT_CHECK_EN
   logic         chk_err;
`endif

   modport master (
      output in_valid, in_a, out_ready,
      input  in_ready, out_valid, out_sqrt, busy, dbg_state
`ifdef GF_SQRT_CHECK_EN
      , input chk_err
`endif
   );

   modport slave (
      input  in_valid, in_a, out_ready,
      output in_ready, out_valid, out_sqrt, busy, dbg_state
`ifdef GF_SQRT_CHECK_EN
      , output chk_err
`endif
   );
endinterface

// File: rtl/gf_sqrt_seq.sv
// -----------------------------------------------------------------------------
// gf_sqrt_seq
// Sequential square root in GF(2^M): sqrt(a) = a^(2^(M-1)), obtained by
// squaring the accepted operand M-1 times, one squaring per clock.
//
// Optional feature macro: GF_SQRT_CHECK_EN
//   When defined, the accepted operand is kept in r_orig and bus.chk_err
//   flags a DONE result whose square does not reproduce it.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   gf_sqrt_seq_if.slave : in_valid/in_ready/in_a, out_valid/out_ready/
//         out_sqrt, busy, dbg_state (and chk_err with GF_SQRT_CHECK_EN)
//
// Parameters
//   M     field degree (>= 2)
//   POLY  primitive polynomial including the x^M term, M+1 bits
// -----------------------------------------------------------------------------
module gf_sqrt_seq #(
   parameter int         M    = 3,
   parameter logic [M:0] POLY = 4'b1011
) (
   input  logic         clk,
   input  logic         rst,
   gf_sqrt_seq_if.slave bus
);

   // GF(2^1) has only 0 and 1, and the count of squarings would be zero.
   generate
      if (M < 2) begin : g_bad_m
         $fatal(1, "gf_sqrt_seq: M must be at least 2");
      end
   endgenerate

   localparam int CW = (M > 2) ? $clog2(M) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [M-1:0]    r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_out_valid;
   logic            r_busy;
   logic [M-1:0]    w_sq;
   logic            w_in_ready;

   // Squaring in characteristic 2: cross terms vanish, so bit i lands on 2i.
   // The 2M-1 bit result is then reduced from the top bit down.
   function automatic logic [M-1:0] f_sq(input logic [M-1:0] x);
      logic [2*M-2:0] p;
      p = '0;
      for (int i = 0; i < M; i++) begin
         p[2*i] = x[i];
      end
      for (int k = 2*M-2; k >= M; k--) begin
         if (p[k]) begin
            p[k-M +: M+1] = p[k-M +: M+1] ^ POLY;
         end
      end
      return p[M-1:0];
   endfunction

   assign w_sq       = f_sq(r_acc);
   assign w_in_ready = (r_state == S_IDLE) ||
                       ((r_state == S_DONE) && bus.out_ready);

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sqrt  = r_acc;
   assign bus.busy      = r_busy;
   assign bus.dbg_state = r_state;

`ifdef GF_SQRT_CHECK_EN
   logic [M-1:0] r_orig;

   // In DONE r_acc is the result, so w_sq must equal the original operand.
   assign bus.chk_err = r_out_valid && (w_sq != r_orig);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_orig <= '0;
      end else if (bus.in_valid && w_in_ready) begin
         r_orig <= bus.in_a;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_acc   <= bus.in_a;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_sq;
               r_cnt <= r_cnt + 1'b1;
               // This edge performs squaring number M-1, the last one.
               if (r_cnt == CW'(M-2)) begin
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (bus.in_valid) begin
                     // Back-to-back: next operand enters as the result leaves.
                     r_acc   <= bus.in_a;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
